// File: rtl/spi_master_arbiter_if.sv
// spi_master_arbiter_if: requester and SPI-master side signals.
// master modport is the arbiter view, slave the environment view.
interface spi_master_arbiter_if #(
  parameter int N_REQ     = 2,
  parameter int WORD_SIZE = 16,
  parameter int CSW       = 1
);
  logic [N_REQ-1:0]           req_valid;
  logic [N_REQ*CSW-1:0]       req_cs;
  logic [N_REQ*WORD_SIZE-1:0] req_data;
  logic [N_REQ-1:0]           req_ack;
  logic [N_REQ-1:0]           resp_valid;
  logic                       resp_err;
  logic [WORD_SIZE-1:0]       resp_data;
  logic                       busy;
  logic                       m_start;
  logic [CSW-1:0]             m_chip_select;
  logic [WORD_SIZE-1:0]       m_tx_data;
  logic                       m_ready;
  logic [WORD_SIZE-1:0]       m_rx_data;

  modport master (
    input  req_valid, req_cs, req_data,
    input  m_ready, m_rx_data,
    output req_ack, resp_valid, resp_err,
    output resp_data, busy,
    output m_start, m_chip_select, m_tx_data
  );

  modport slave (
    output req_valid, req_cs, req_data,
    output m_ready, m_rx_data,
    input  req_ack, resp_valid, resp_err,
    input  resp_data, busy,
    input  m_start, m_chip_select, m_tx_data
  );
endinterface

// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter: round-robin sharing of one SPI master.
// Latches the winner's request, runs it, returns RX word or error.
module spi_master_arbiter #(
  parameter int N_REQ         = 2,
  parameter int WORD_SIZE     = 16,
  parameter int SLAVE_COUNT   = 2,
  parameter int START_TIMEOUT = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  spi_master_arbiter_if.master bus
);
  localparam int CSW = $clog2(SLAVE_COUNT);
  localparam int PW  = $clog2(N_REQ);
  localparam int TW  = $clog2(START_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_BUSY
  } state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [PW-1:0]        owner_q, owner_d;
  logic [TW-1:0]        cnt_q, cnt_d;
  logic [N_REQ-1:0]     ack_q, ack_d;
  logic [N_REQ-1:0]     rv_q, rv_d;
  logic                 err_q, err_d;
  logic [WORD_SIZE-1:0] rdata_q, rdata_d;
  logic                 busy_q, busy_d;
  logic                 start_q, start_d;
  logic [CSW-1:0]       cs_q, cs_d;
  logic [WORD_SIZE-1:0] tx_q, tx_d;

  logic                 found;
  logic [PW-1:0]        win;

  // first pending requester at or after ptr, wrapping
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found &&
          bus.req_valid[(int'(ptr_q) + k) % N_REQ]) begin
        found = 1'b1;
        win   = PW'((int'(ptr_q) + k) % N_REQ);
      end
    end
  end

  // grant / issue / wait sequencing and output next-state
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    rv_d    = '0;
    err_d   = err_q;
    rdata_d = rdata_q;
    busy_d  = busy_q;
    start_d = start_q;
    cs_d    = cs_q;
    tx_d    = tx_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.m_ready && found) begin
          owner_d    = win;
          ptr_d      = (int'(win) == N_REQ - 1) ?
                       '0 : win + 1'b1;
          ack_d[win] = 1'b1;
          cs_d       = bus.req_cs[int'(win) * CSW +: CSW];
          tx_d       = bus.req_data[int'(win) * WORD_SIZE
                                    +: WORD_SIZE];
          start_d    = 1'b1;
          busy_d     = 1'b1;
          cnt_d      = '0;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!bus.m_ready) begin
          start_d = 1'b0;
          state_d = S_BUSY;
        end else if (cnt_q == TW'(START_TIMEOUT - 1)) begin
          start_d       = 1'b0;
          rv_d[owner_q] = 1'b1;
          err_d         = 1'b1;
          rdata_d       = '0;
          busy_d        = 1'b0;
          state_d       = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BUSY: begin
        if (bus.m_ready) begin
          rdata_d       = bus.m_rx_data;
          err_d         = 1'b0;
          rv_d[owner_q] = 1'b1;
          busy_d        = 1'b0;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      rv_q    <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      cs_q    <= '0;
      tx_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      rv_q    <= rv_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      cs_q    <= cs_d;
      tx_q    <= tx_d;
    end
  end

  assign bus.req_ack       = ack_q;
  assign bus.resp_valid    = rv_q;
  assign bus.resp_err      = err_q;
  assign bus.resp_data     = rdata_q;
  assign bus.busy          = busy_q;
  assign bus.m_start       = start_q;
  assign bus.m_chip_select = cs_q;
  assign bus.m_tx_data     = tx_q;
endmodule

// File: tb/tb_spi_master_arbiter.sv
// tb_spi_master_arbiter: directed + random bench with a
// transaction-level reference model of the arbiter.
module tb_spi_master_arbiter;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  spi_master_arbiter_if #(.N_REQ(N), .WORD_SIZE(W), .CSW(1)) ifc();

  spi_master_arbiter #(
    .N_REQ(N), .WORD_SIZE(W),
    .SLAVE_COUNT(2), .START_TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(ifc)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // One transfer at a time: who owns it, how many cycles the
  // start offer has been visible, and whether the master took it.
  int         m_ptr, m_owner, m_wait;
  bit         m_acc;
  logic [N-1:0] e_ack, e_rv;
  logic         e_err, e_busy, e_start, e_cs;
  logic [W-1:0] e_rdata, e_tx;

  task automatic reset_model();
    m_ptr = 0; m_owner = -1; m_wait = 0; m_acc = 0;
    e_ack = '0; e_rv = '0; e_err = 0; e_busy = 0;
    e_start = 0; e_cs = 0; e_rdata = '0; e_tx = '0;
  endtask

  task automatic end_xfer(input logic err, input logic [W-1:0] d);
    e_start = 0; e_busy = 0; e_err = err; e_rdata = d;
    e_rv[m_owner] = 1'b1;
    m_owner = -1;
  endtask

  task automatic advance();
    int w;
    e_ack = '0;
    e_rv  = '0;
    if (m_owner < 0) begin
      w = -1;
      if (ifc.m_ready)
        for (int k = 0; k < N; k++)
          if (w < 0 && ifc.req_valid[(m_ptr + k) % N])
            w = (m_ptr + k) % N;
      if (w >= 0) begin
        m_owner = w; m_ptr = (w + 1) % N;
        m_wait = 0; m_acc = 0;
        e_ack[w] = 1'b1; e_start = 1; e_busy = 1;
        e_cs = ifc.req_cs[w];
        e_tx = ifc.req_data[w*W +: W];
      end
    end else if (!m_acc) begin
      m_wait++;
      if (!ifc.m_ready) begin
        m_acc = 1; e_start = 0;
      end else if (m_wait == TO) begin
        end_xfer(1'b1, '0);
      end
    end else if (ifc.m_ready) begin
      end_xfer(1'b0, ifc.m_rx_data);
    end
  endtask

  // compare every cycle on negedge, step model on posedge
  initial begin
    reset_model();
    forever begin
      @(negedge clk);
      if (!reset_n) reset_model();
      check("outputs",
        64'({ifc.req_ack, ifc.resp_valid, ifc.resp_err,
             ifc.resp_data, ifc.busy, ifc.m_start,
             ifc.m_chip_select, ifc.m_tx_data}),
        64'({e_ack, e_rv, e_err, e_rdata, e_busy,
             e_start, e_cs, e_tx}));
      @(posedge clk);
      if (!reset_n) reset_model();
      else advance();
    end
  end

  // ---------------- SPI master stand-in ----------------
  bit master_en = 0, ignore_start = 0, jitter = 0;
  int lat = 0, acc = 0;

  initial begin
    ifc.m_ready = 0;
    ifc.m_rx_data = '0;
    forever begin
      @(posedge clk); #1;
      if (jitter && $urandom_range(0, 19) == 0)
        ignore_start = !ignore_start;
      if (!reset_n || !master_en) begin
        ifc.m_ready = 0; lat = 0; acc = 0;
      end else if (lat > 0) begin
        lat--;
        if (lat == 0) begin
          ifc.m_ready = 1;
          ifc.m_rx_data = ifc.m_tx_data ^ 16'h9966;
        end
      end else if (ifc.m_start && !ignore_start) begin
        if (acc == 0) acc = $urandom_range(1, 3);
        acc--;
        if (acc == 0) begin
          ifc.m_ready = 0;
          lat = $urandom_range(1, 6);
        end
      end else begin
        acc = 0;
        ifc.m_ready = jitter ? ($urandom_range(0, 7) != 0) : 1'b1;
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic set_req(input int i, input logic cs,
                         input logic [W-1:0] d);
    ifc.req_valid[i] = 1'b1;
    ifc.req_cs[i] = cs;
    ifc.req_data[i*W +: W] = d;
  endtask

  task automatic wait_ack(input int idx);
    logic [N-1:0] oh;
    int n = 0;
    oh = '0; oh[idx] = 1'b1;
    do begin @(negedge clk); n++; end
    while (ifc.req_ack == '0 && n < 60);
    check("req_ack", 64'(ifc.req_ack), 64'(oh));
    check("m_start_on_ack", 64'(ifc.m_start), 64'd1);
  endtask

  task automatic chk_resp(input int idx, input logic err,
                          input logic [W-1:0] d);
    logic [N-1:0] oh;
    oh = '0; oh[idx] = 1'b1;
    check("resp_valid", 64'(ifc.resp_valid), 64'(oh));
    check("resp_err", 64'(ifc.resp_err), 64'(err));
    check("resp_data", 64'(ifc.resp_data), 64'(d));
    check("busy_fall", 64'(ifc.busy), 64'd0);
  endtask

  task automatic wait_resp(input int idx, input logic err,
                           input logic [W-1:0] d);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (ifc.resp_valid == '0 && n < 80);
    chk_resp(idx, err, d);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, n_on;
    logic [W-1:0] d;
    reset_n = 1;
    ifc.req_valid = '0; ifc.req_cs = '0; ifc.req_data = '0;
    #1 reset_n = 0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1;

    // no grant before m_ready is ever seen high
    set_req(0, 1'b1, 16'hA55A);
    repeat (4) @(negedge clk);
    check("no_grant_wo_ready",
      64'({ifc.req_ack, ifc.m_start, ifc.busy}), 64'd0);
    master_en = 1;
    wait_ack(0);
    check("t1_cs", 64'(ifc.m_chip_select), 64'd1);
    check("t1_tx", 64'(ifc.m_tx_data), 64'h A55A);
    ifc.req_valid[0] = 0;
    wait_resp(0, 1'b0, 16'h3C3C);

    // lone requester wins whatever ptr is (ptr 1 -> 0)
    set_req(3, 1'b0, 16'h0F0F);
    wait_ack(3);
    ifc.req_valid[3] = 0;
    wait_resp(3, 1'b0, 16'h0F0F ^ 16'h9966);

    // both held: alternate 0,1,0,1
    set_req(0, 1'b0, 16'h1111);
    set_req(1, 1'b1, 16'h2222);
    for (int t = 0; t < 4; t++) begin
      d = (t % 2) ? 16'h2222 : 16'h1111;
      wait_ack(t % 2);
      check("t3_tx", 64'(ifc.m_tx_data), 64'(d));
      if (t == 3) ifc.req_valid = '0;
      wait_resp(t % 2, 1'b0, d ^ 16'h9966);
    end

    // ptr back to 0, then 1010 -> 1,3,1
    set_req(3, 1'b1, 16'hCAFE);
    wait_ack(3);
    ifc.req_valid[3] = 0;
    wait_resp(3, 1'b0, 16'hCAFE ^ 16'h9966);
    set_req(1, 1'b0, 16'h1357);
    set_req(3, 1'b1, 16'h2468);
    for (int t = 0; t < 3; t++) begin
      d = (t == 1) ? 16'h2468 : 16'h1357;
      wait_ack((t == 1) ? 3 : 1);
      if (t == 2) ifc.req_valid = '0;
      wait_resp((t == 1) ? 3 : 1, 1'b0, d ^ 16'h9966);
    end

    // start never accepted -> TO cycles then error
    ignore_start = 1;
    set_req(2, 1'b0, 16'h5555);
    wait_ack(2);
    ifc.req_valid[2] = 0;
    n_on = 1; n = 0;
    do begin
      @(negedge clk); n++;
      if (ifc.resp_valid == '0 && ifc.m_start) n_on++;
    end while (ifc.resp_valid == '0 && n < 40);
    check("issue_cycles", 64'(n_on), 64'(TO));
    chk_resp(2, 1'b1, 16'h0000);
    ignore_start = 0;
    set_req(0, 1'b1, 16'hBEEF);
    wait_ack(0);
    ifc.req_valid[0] = 0;
    wait_resp(0, 1'b0, 16'hBEEF ^ 16'h9966);

    // reset in the middle of BUSY
    set_req(1, 1'b0, 16'h7777);
    wait_ack(1);
    ifc.req_valid[1] = 0;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(ifc.busy && !ifc.m_start) && n < 20);
    check("reach_busy", 64'({ifc.busy, ifc.m_start}), 64'b10);
    master_en = 0;
    #2 reset_n = 0;
    #1 check("async_reset_outs",
      64'({ifc.req_ack, ifc.resp_valid, ifc.resp_err,
           ifc.resp_data, ifc.busy, ifc.m_start,
           ifc.m_chip_select, ifc.m_tx_data}), 64'd0);
    set_req(0, 1'b0, 16'h1234);
    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    repeat (3) @(negedge clk);
    check("no_resp_after_reset",
      64'({ifc.req_ack, ifc.resp_valid, ifc.busy}), 64'd0);
    master_en = 1;
    wait_ack(0);
    check("t6_tx", 64'(ifc.m_tx_data), 64'h1234);
    ifc.req_valid[0] = 0;
    wait_resp(0, 1'b0, 16'h1234 ^ 16'h9966);

    // random traffic; the model checks every cycle
    @(negedge clk);
    jitter = 1;
    repeat (3000) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (ifc.req_ack[i]) begin
          ifc.req_valid[i] = 1'($urandom_range(0, 1));
          ifc.req_cs[i] = 1'($urandom_range(0, 1));
          ifc.req_data[i*W +: W] = 16'($urandom);
        end else if (!ifc.req_valid[i] &&
                     $urandom_range(0, 3) == 0) begin
          set_req(i, 1'($urandom_range(0, 1)), 16'($urandom));
        end
      end
    end
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
